// File: rtl/sdram_rmw_engine_pkg.sv
// Shared definitions for the SDRAM read-modify-write engine.
//   CMD_*   : command encodings driven on o_Command
//   state_e : engine FSM states
//   mode_e  : per-lane operation selected at pass start
package sdram_rmw_engine_pkg;

  localparam int unsigned CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_IDLE  = 2'd0;
  localparam logic [CMD_W-1:0] CMD_READ  = 2'd1;
  localparam logic [CMD_W-1:0] CMD_WRITE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_RD = 3'd1,
    S_READ   = 3'd2,
    S_PROC   = 3'd3,
    S_REQ_WR = 3'd4,
    S_WRITE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADD_WRAP = 2'd0,
    MODE_ADD_SAT  = 2'd1,
    MODE_FILL     = 2'd2,
    MODE_COPY     = 2'd3
  } mode_e;

endpackage

// File: rtl/sdram_rmw_engine_lane_alu.sv
// Combinational per-lane operation applied to one buffered word.
//   mode     : operation select (wrap add, saturating add, fill, copy)
//   operand  : lane operand
//   data     : input word, NLANES independent lanes
//   result_c : processed word (combinational)
module rmw_lane_alu
  import sdram_rmw_engine_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 8
) (
  input  mode_e              mode,
  input  logic [LANE_W-1:0]  operand,
  input  logic [DATA_W-1:0]  data,
  output logic [DATA_W-1:0]  result_c
);

  localparam int unsigned NLANES = DATA_W / LANE_W;

  logic [LANE_W:0]   sum;
  logic [LANE_W-1:0] lane;

  // Each lane is summed with a private carry bit so nothing crosses a lane boundary
  always_comb begin
    result_c = data;
    sum      = '0;
    lane     = '0;
    for (int l = 0; l < int'(NLANES); l++) begin
      lane = data[l*LANE_W +: LANE_W];
      sum  = {1'b0, lane} + {1'b0, operand};
      case (mode)
        MODE_ADD_WRAP: result_c[l*LANE_W +: LANE_W] = sum[LANE_W-1:0];
        MODE_ADD_SAT:  result_c[l*LANE_W +: LANE_W] = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
        MODE_FILL:     result_c[l*LANE_W +: LANE_W] = operand;
        default:       result_c[l*LANE_W +: LANE_W] = lane;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rmw_engine.sv
// Burst-wise read-modify-write engine walking a framebuffer region in SDRAM.
// Reads BURST_LEN words into a local buffer, processes them one per cycle,
// writes them back to the same addresses, then moves to the next burst.
//   i_Clk, i_Reset_n        : clock, asynchronous active-low reset
//   i_Start, i_Mode,
//   i_Operand               : pass start request and its configuration
//   i_Data_Read_Valid,
//   i_Data_Read             : read word handshake from the controller
//   i_Data_Write_Done       : controller accepted o_Data_Write
//   i_SDRAM_Requested       : another master wants the port
//   o_SDRAM_Yield           : port released (requested and no command held)
//   o_Command               : CMD_IDLE / CMD_READ / CMD_WRITE
//   o_Data_Address          : current word address
//   o_Data_Write            : word to write
//   o_Busy, o_Pass_Done     : pass in progress, end-of-pass pulse
module sdram_rmw_engine
  import sdram_rmw_engine_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LANE_W       = 8,
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned REGION_BASE  = 0,
  parameter int unsigned REGION_WORDS = 96000,
  parameter int unsigned CONTINUOUS   = 0
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  input  logic [1:0]        i_Mode,
  input  logic [LANE_W-1:0] i_Operand,
  input  logic              i_Data_Read_Valid,
  input  logic              i_Data_Write_Done,
  input  logic [DATA_W-1:0] i_Data_Read,
  input  logic              i_SDRAM_Requested,
  output logic              o_SDRAM_Yield,
  output logic [CMD_W-1:0]  o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  output logic              o_Busy,
  output logic              o_Pass_Done
);

  localparam int unsigned NLANES    = DATA_W / LANE_W;
  localparam int unsigned IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned LAST_BASE = REGION_BASE + REGION_WORDS - BURST_LEN;

  // Elaboration-time parameter sanity
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("sdram_rmw_engine: BURST_LEN must be >= 1");
  end
  if ((REGION_WORDS == 0) || ((REGION_WORDS % BURST_LEN) != 0)) begin : g_bad_region
    $error("sdram_rmw_engine: REGION_WORDS must be a non-zero multiple of BURST_LEN");
  end
  if ((DATA_W % LANE_W) != 0) begin : g_bad_lane
    $error("sdram_rmw_engine: DATA_W must be a multiple of LANE_W");
  end

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  mode_e               mode_q, mode_d;
  logic [LANE_W-1:0]   operand_q, operand_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   buffer_q [BURST_LEN];
  logic                buf_we;
  logic [IDX_W-1:0]    buf_idx;
  logic [DATA_W-1:0]   buf_wdata;

  mode_e               mode_in_c;
  logic [DATA_W-1:0]   alu_result_c;
  logic [DATA_W-1:0]   fill_word_c;
  logic                last_idx_c;
  logic                region_end_c;

  assign mode_in_c    = mode_e'(i_Mode);
  assign fill_word_c  = {NLANES{operand_q}};
  assign last_idx_c   = (idx_q == IDX_W'(BURST_LEN - 1));
  assign region_end_c = (base_q == ADDR_W'(LAST_BASE));

  // Single lane ALU serving the PROC walk over the buffer
  rmw_lane_alu #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_alu (
    .mode     (mode_q),
    .operand  (operand_q),
    .data     (buffer_q[idx_q]),
    .result_c (alu_result_c)
  );

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_IDLE;
      addr_q    <= ADDR_W'(REGION_BASE);
      base_q    <= ADDR_W'(REGION_BASE);
      idx_q     <= '0;
      mode_q    <= MODE_ADD_WRAP;
      operand_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      operand_q <= operand_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wdata_q   <= wdata_d;
    end
  end

  // Burst buffer; contents are don't-care out of reset
  always_ff @(posedge i_Clk) begin
    if (buf_we) begin
      buffer_q[buf_idx] <= buf_wdata;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    base_d    = base_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    operand_d = operand_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wdata_d   = wdata_q;
    buf_we    = 1'b0;
    buf_idx   = idx_q;
    buf_wdata = alu_result_c;

    case (state_q)
      S_IDLE: begin
        // busy trails the pass-done pulse by one cycle so a start coincident
        // with the pulse is still rejected
        busy_d = 1'b0;
        if (i_Start && !busy_q) begin
          mode_d    = mode_in_c;
          operand_d = i_Operand;
          busy_d    = 1'b1;
          state_d   = (mode_in_c == MODE_FILL) ? S_REQ_WR : S_REQ_RD;
        end
      end

      S_REQ_RD: begin
        if (!i_SDRAM_Requested) begin
          cmd_d   = CMD_READ;
          addr_d  = base_q;
          idx_d   = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (i_Data_Read_Valid) begin
          buf_we    = 1'b1;
          buf_wdata = i_Data_Read;
          idx_d     = idx_q + IDX_W'(1);
          addr_d    = addr_q + ADDR_W'(1);
          if (last_idx_c) begin
            cmd_d   = CMD_IDLE;
            idx_d   = '0;
            state_d = S_PROC;
          end
        end
      end

      S_PROC: begin
        buf_we = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (last_idx_c) begin
          idx_d   = '0;
          state_d = S_REQ_WR;
        end
      end

      S_REQ_WR: begin
        if (!i_SDRAM_Requested) begin
          cmd_d   = CMD_WRITE;
          addr_d  = base_q;
          idx_d   = '0;
          wdata_d = (mode_q == MODE_FILL) ? fill_word_c : buffer_q[0];
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (i_Data_Write_Done) begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = addr_q + ADDR_W'(1);
          if (!last_idx_c) begin
            wdata_d = (mode_q == MODE_FILL) ? fill_word_c : buffer_q[idx_q + IDX_W'(1)];
          end else begin
            cmd_d = CMD_IDLE;
            idx_d = '0;
            if (region_end_c) begin
              base_d = ADDR_W'(REGION_BASE);
              done_d = 1'b1;
              if (CONTINUOUS != 0) begin
                mode_d    = mode_in_c;
                operand_d = i_Operand;
                state_d   = (mode_in_c == MODE_FILL) ? S_REQ_WR : S_REQ_RD;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              base_d  = base_q + ADDR_W'(BURST_LEN);
              state_d = (mode_q == MODE_FILL) ? S_REQ_WR : S_REQ_RD;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cmd_d   = CMD_IDLE;
      end
    endcase
  end

  assign o_SDRAM_Yield  = i_SDRAM_Requested && (cmd_q == CMD_IDLE);
  assign o_Command      = cmd_q;
  assign o_Data_Address = addr_q;
  assign o_Data_Write   = wdata_q;
  assign o_Busy         = busy_q;
  assign o_Pass_Done    = done_q;

endmodule

// File: tb/tb_sdram_rmw_engine.sv
// Bench for sdram_rmw_engine: a controller/memory model answers the engine's
// commands, and every write is checked against per-lane arithmetic on the
// memory contents. Instance 0 runs single passes over words 0..7, instance 1
// runs continuously over words 16..23.
module tb_sdram_rmw_engine;

  localparam int BL = 4;
  localparam int RW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start   [2];
  logic [1:0]  mode_in [2];
  logic [7:0]  op_in   [2];
  logic        rv      [2];
  logic        wd      [2];
  logic [31:0] rdata   [2];
  logic        req     [2];
  logic        yield   [2];
  logic [1:0]  cmd     [2];
  logic [21:0] addr    [2];
  logic [31:0] wdat    [2];
  logic        busy    [2];
  logic        pd      [2];

  sdram_rmw_engine #(
    .DATA_W(32), .LANE_W(8), .ADDR_W(22), .BURST_LEN(BL),
    .REGION_BASE(0), .REGION_WORDS(RW), .CONTINUOUS(0)
  ) u_dut0 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start[0]), .i_Mode(mode_in[0]),
    .i_Operand(op_in[0]), .i_Data_Read_Valid(rv[0]), .i_Data_Write_Done(wd[0]),
    .i_Data_Read(rdata[0]), .i_SDRAM_Requested(req[0]), .o_SDRAM_Yield(yield[0]),
    .o_Command(cmd[0]), .o_Data_Address(addr[0]), .o_Data_Write(wdat[0]),
    .o_Busy(busy[0]), .o_Pass_Done(pd[0])
  );

  sdram_rmw_engine #(
    .DATA_W(32), .LANE_W(8), .ADDR_W(22), .BURST_LEN(BL),
    .REGION_BASE(16), .REGION_WORDS(RW), .CONTINUOUS(1)
  ) u_dut1 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start[1]), .i_Mode(mode_in[1]),
    .i_Operand(op_in[1]), .i_Data_Read_Valid(rv[1]), .i_Data_Write_Done(wd[1]),
    .i_Data_Read(rdata[1]), .i_SDRAM_Requested(req[1]), .o_SDRAM_Yield(yield[1]),
    .o_Command(cmd[1]), .o_Data_Address(addr[1]), .o_Data_Write(wdat[1]),
    .o_Busy(busy[1]), .o_Pass_Done(pd[1])
  );

  logic [31:0] mem     [32];
  logic [31:0] exp_mem [32];
  int          rd_ptr  [2];
  int          wr_ptr  [2];
  int          pass_mode [4];
  int          pass_op   [4];
  int          n_cmp = 0;
  int          n_fail = 0;

  // Per-lane reference operation on a 4x8-bit word
  function automatic logic [31:0] ref_op(input int mode, input int op, input logic [31:0] w);
    logic [31:0] res;
    int a, r;
    res = 32'h0;
    for (int l = 0; l < 4; l++) begin
      a = int'((w >> (8 * l)) & 32'hFF);
      case (mode)
        0:       r = (a + op) % 256;
        1:       r = (a + op > 255) ? 255 : a + op;
        2:       r = op;
        default: r = a;
      endcase
      res = res | (32'(r) << (8 * l));
    end
    return res;
  endfunction

  function automatic int base_of(input int d);
    return (d == 0) ? 0 : 16;
  endfunction

  // Drives one engine through npasses passes acting as the SDRAM controller.
  // req_style: 0 never requested, 1 random requests, 2 held over a read burst
  // and the following processing window. abort_writes>0 returns mid-write.
  task automatic run(input int d, input int npasses, input int stall, input int req_style,
                     input int abort_writes, output int passes);
    int base, pidx, hs, cyc, phase, hold, a;
    logic [1:0]  c, pc;
    logic [31:0] expw;
    bit go, resume_chk, aborted;
    base = base_of(d); pidx = 0; hs = 0; cyc = 0; phase = 0; hold = 0;
    passes = 0; resume_chk = 0; aborted = 0;
    rd_ptr[d] = base; wr_ptr[d] = base;
    @(negedge clk);
    start[d] = 1'b1; mode_in[d] = 2'(pass_mode[0]); op_in[d] = 8'(pass_op[0]);
    req[d] = 1'b0; rv[d] = 1'b0; wd[d] = 1'b0;
    pc = cmd[d];
    while (1) begin
      @(negedge clk);
      cyc++;
      start[d] = 1'b0;
      if (cyc == 1 && d == 1) begin
        mode_in[d] = 2'(pass_mode[1]); op_in[d] = 8'(pass_op[1]);
      end
      c = cmd[d];
      a = int'(addr[d]);
      if (cyc > 3000) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout dut%0d: passes %0d required %0d", d, passes, npasses);
        break;
      end
      n_cmp++;
      if (yield[d] !== (req[d] && c == 2'd0)) begin
        n_fail++; $display("FAIL yield dut%0d: got %b req %b cmd %0d", d, yield[d], req[d], c);
      end
      n_cmp++;
      if (busy[d] !== 1'b1) begin
        n_fail++; $display("FAIL busy_in_pass dut%0d: got %b required 1", d, busy[d]);
      end
      if (resume_chk) begin
        resume_chk = 0; n_cmp++;
        if (c == 2'd0) begin
          n_fail++; $display("FAIL continuous_resume dut%0d: cmd %0d required non-idle", d, c);
        end
      end
      if (pc == 2'd0 && c != 2'd0) begin
        n_cmp++;
        if (req[d] !== 1'b0) begin
          n_fail++; $display("FAIL cmd_during_req dut%0d: cmd %0d issued with req %b", d, c, req[d]);
        end
        n_cmp++;
        if (pass_mode[pidx] == 2 && c == 2'd1) begin
          n_fail++; $display("FAIL fill_read dut%0d: cmd READ at addr %0d required none", d, a);
        end
        hs = 0;
      end
      if (pc != 2'd0 && c == 2'd0) begin
        n_cmp++;
        if (hs != BL) begin
          n_fail++; $display("FAIL burst_len dut%0d: %0d handshakes required %0d", d, hs, BL);
        end
      end
      if (pd[d]) begin
        pidx++; passes++;
        if (d == 1 && pidx < npasses) begin
          mode_in[d] = 2'(pass_mode[pidx + 1]); op_in[d] = 8'(pass_op[pidx + 1]);
          if (req_style == 0) resume_chk = 1;
        end
      end
      if (abort_writes > 0 && c == 2'd2 && hs == abort_writes) begin
        aborted = 1; rv[d] = 1'b0; wd[d] = 1'b0;
        break;
      end
      // Controller response for the coming edge
      rv[d] = 1'b0; wd[d] = 1'b0; rdata[d] = $urandom;
      go = (stall == 0) || ($urandom_range(3) != 0);
      if (c == 2'd1 && go) begin
        n_cmp++;
        if (a != rd_ptr[d]) begin
          n_fail++; $display("FAIL rd_addr dut%0d: got %0d required %0d", d, a, rd_ptr[d]);
        end
        rdata[d] = mem[a % 32]; rv[d] = 1'b1; hs++;
        rd_ptr[d]++; if (rd_ptr[d] == base + RW) rd_ptr[d] = base;
      end else if (c == 2'd2 && go) begin
        expw = ref_op(pass_mode[pidx], pass_op[pidx], mem[a % 32]);
        n_cmp++;
        if (a != wr_ptr[d]) begin
          n_fail++; $display("FAIL wr_addr dut%0d: got %0d required %0d", d, a, wr_ptr[d]);
        end
        n_cmp++;
        if (wdat[d] !== expw) begin
          n_fail++; $display("FAIL wr_data dut%0d @%0d: got %h required %h", d, a, wdat[d], expw);
        end
        mem[a % 32] = wdat[d]; wd[d] = 1'b1; hs++;
        wr_ptr[d]++; if (wr_ptr[d] == base + RW) wr_ptr[d] = base;
      end else if (c == 2'd0 && stall != 0 && $urandom_range(3) == 0) begin
        rv[d] = 1'b1; wd[d] = 1'b1;
      end
      if (d == 0 && stall != 0 && $urandom_range(15) == 0) begin
        start[d] = 1'b1; mode_in[d] = 2'($urandom_range(3));
      end
      case (req_style)
        1: req[d] = ($urandom_range(2) == 0);
        2: begin
          if (phase == 0 && c == 2'd1) phase = 1;
          else if (phase == 1 && c == 2'd0) begin phase = 2; hold = 0; end
          else if (phase == 2) begin
            n_cmp++;
            if (c != 2'd0) begin
              n_fail++; $display("FAIL yield_hold dut%0d: cmd %0d while requested", d, c);
            end
            hold++; if (hold == 20) phase = 3;
          end
          req[d] = (phase == 1 || phase == 2);
        end
        default: req[d] = 1'b0;
      endcase
      pc = c;
      if (pidx >= npasses) begin
        if (d == 0) begin start[d] = 1'b1; mode_in[d] = 2'd0; end
        break;
      end
    end
    if (d == 0 && !aborted && passes >= npasses) begin
      @(negedge clk);
      start[d] = 1'b0; rv[d] = 1'b0; wd[d] = 1'b0; req[d] = 1'b0;
      n_cmp++;
      if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b required 0", busy[d]); end
      n_cmp++;
      if (pd[d] !== 1'b0) begin n_fail++; $display("FAIL pass_done_width: got %b required 0", pd[d]); end
      repeat (3) begin
        @(negedge clk);
        n_cmp++;
        if (cmd[d] !== 2'd0 || busy[d] !== 1'b0) begin
          n_fail++; $display("FAIL idle_after_pass: cmd %0d busy %b required 0/0", cmd[d], busy[d]);
        end
      end
    end else begin
      start[d] = 1'b0; rv[d] = 1'b0; wd[d] = 1'b0; req[d] = 1'b0;
    end
  endtask

  task automatic fill_region(input int d, input bit rnd, input logic [31:0] w);
    for (int i = base_of(d); i < base_of(d) + RW; i++) mem[i] = rnd ? $urandom : w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 0; mode_in[d] = 0; op_in[d] = 0; rv[d] = 0; wd[d] = 0; rdata[d] = 0; req[d] = 0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (cmd[d] !== 2'd0 || busy[d] !== 1'b0 || pd[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_ctrl dut%0d: cmd %0d busy %b pd %b", d, cmd[d], busy[d], pd[d]);
      end
      n_cmp++;
      if (int'(addr[d]) != base_of(d)) begin
        n_fail++; $display("FAIL reset_addr dut%0d: got %0d required %0d", d, addr[d], base_of(d));
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd[0] !== 2'd0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: cmd %0d busy %b", cmd[0], busy[0]);
    end
  endtask

  task automatic test_add_wrap();
    int p;
    fill_region(0, 0, 32'h00FF7F10);
    pass_mode[0] = 0; pass_op[0] = 8'h01;
    run(0, 1, 0, 0, 0, p);
    for (int i = 0; i < RW; i++) begin
      n_cmp++;
      if (mem[i] !== 32'h01008011) begin
        n_fail++; $display("FAIL add_wrap @%0d: got %h required 01008011", i, mem[i]);
      end
    end
  endtask

  task automatic test_add_sat();
    int p;
    fill_region(0, 0, 32'hF5FFEE00);
    pass_mode[0] = 1; pass_op[0] = 8'h10;
    run(0, 1, 0, 0, 0, p);
    for (int i = 0; i < RW; i++) begin
      n_cmp++;
      if (mem[i] !== 32'hFFFFFE10) begin
        n_fail++; $display("FAIL add_sat @%0d: got %h required FFFFFE10", i, mem[i]);
      end
    end
  endtask

  task automatic test_fill();
    int p;
    fill_region(0, 1, 32'h0);
    pass_mode[0] = 2; pass_op[0] = 8'hAB;
    run(0, 1, 1, 0, 0, p);
    for (int i = 0; i < RW; i++) begin
      n_cmp++;
      if (mem[i] !== 32'hABABABAB) begin
        n_fail++; $display("FAIL fill @%0d: got %h required ABABABAB", i, mem[i]);
      end
    end
  endtask

  task automatic test_yield();
    int p;
    fill_region(0, 1, 32'h0);
    pass_mode[0] = 0; pass_op[0] = int'($urandom_range(255));
    for (int i = 0; i < RW; i++) exp_mem[i] = ref_op(pass_mode[0], pass_op[0], mem[i]);
    run(0, 1, 0, 2, 0, p);
    for (int i = 0; i < RW; i++) begin
      n_cmp++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL yield_result @%0d: got %h required %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    int p;
    for (int it = 0; it < 6; it++) begin
      fill_region(0, 1, 32'h0);
      pass_mode[0] = int'($urandom_range(3)); pass_op[0] = int'($urandom_range(255));
      for (int i = 0; i < RW; i++) exp_mem[i] = ref_op(pass_mode[0], pass_op[0], mem[i]);
      run(0, 1, 1, 1, 0, p);
      for (int i = 0; i < RW; i++) begin
        n_cmp++;
        if (mem[i] !== exp_mem[i]) begin
          n_fail++; $display("FAIL random it%0d @%0d: got %h required %h", it, i, mem[i], exp_mem[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int p;
    fill_region(0, 1, 32'h0);
    pass_mode[0] = 3; pass_op[0] = 0;
    run(0, 1, 0, 0, 2, p);
    n_cmp++;
    if (cmd[0] !== 2'd2) begin
      n_fail++; $display("FAIL abort_point: cmd %0d required WRITE", cmd[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cmd[0] !== 2'd0) begin
      n_fail++; $display("FAIL async_reset_cmd: got %0d required 0", cmd[0]);
    end
    n_cmp++;
    if (busy[0] !== 1'b0 || addr[0] !== 22'd0) begin
      n_fail++; $display("FAIL async_reset_state: busy %b addr %0d", busy[0], addr[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    pass_mode[0] = 1; pass_op[0] = int'($urandom_range(255));
    for (int i = 0; i < RW; i++) exp_mem[i] = ref_op(pass_mode[0], pass_op[0], mem[i]);
    run(0, 1, 0, 0, 0, p);
    for (int i = 0; i < RW; i++) begin
      n_cmp++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL restart @%0d: got %h required %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_continuous();
    int p;
    logic [31:0] v;
    fill_region(1, 1, 32'h0);
    pass_mode[0] = 0; pass_mode[1] = 2; pass_mode[2] = 1; pass_mode[3] = 3;
    for (int k = 0; k < 4; k++) pass_op[k] = int'($urandom_range(255));
    for (int i = 16; i < 16 + RW; i++) begin
      v = mem[i];
      for (int k = 0; k < 3; k++) v = ref_op(pass_mode[k], pass_op[k], v);
      exp_mem[i] = v;
    end
    run(1, 3, 0, 0, 0, p);
    n_cmp++;
    if (p != 3) begin
      n_fail++; $display("FAIL continuous_passes: got %0d required 3", p);
    end
    for (int i = 16; i < 16 + RW; i++) begin
      n_cmp++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL continuous @%0d: got %h required %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_add_sat();
    test_fill();
    test_yield();
    test_random();
    test_reset_mid_write();
    test_continuous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
